// File: rtl/keypad_scanner_if.sv
// Key event channel from the keypad scanner to its consumer (calculator FSM).
// key_code is held between events; data_ready marks the single cycle it changes.
interface keypad_scanner_if;
    logic [3:0] key_code;
    logic       data_ready;

    modport master (
        output key_code,
        output data_ready
    );

    modport slave (
        input  key_code,
        input  data_ready
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with per-slot sampling, press/release debouncing and
// one data_ready pulse per accepted press; key_code = {row, col}.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEBOUNCE_CNT = 4
) (
    input  logic             clk,
    input  logic             reset_in,
    output logic [3:0]       row_out,
    input  logic [3:0]       col_in,
    keypad_scanner_if.master key_if
);

    localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    // Count value at which the current matching sample is the DEBOUNCE_CNT-th one
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    function automatic logic [1:0] lowest_low_col(input logic [3:0] col);
        logic [1:0] idx;
        if (!col[0]) begin
            idx = 2'd0;
        end else if (!col[1]) begin
            idx = 2'd1;
        end else if (!col[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] row);
        logic [1:0] idx;
        case (row)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // A corrupted row pattern falls back to row 0 instead of driving several rows
    function automatic logic [3:0] next_row(input logic [3:0] row);
        logic [3:0] nxt;
        case (row)
            4'b1110: nxt = 4'b1101;
            4'b1101: nxt = 4'b1011;
            4'b1011: nxt = 4'b0111;
            4'b0111: nxt = 4'b1110;
            default: nxt = 4'b1110;
        endcase
        return nxt;
    endfunction

    logic [3:0]        col_meta_q;
    logic [3:0]        col_s_q;
    logic [SLOT_W-1:0] slot_cnt_q;
    logic [SLOT_W-1:0] slot_cnt_d;
    logic [3:0]        row_q;
    logic [3:0]        row_d;
    state_t            state_q;
    state_t            state_d;
    logic [DEB_W-1:0]  deb_cnt_q;
    logic [DEB_W-1:0]  deb_cnt_d;
    logic [1:0]        cap_row_q;
    logic [1:0]        cap_row_d;
    logic [1:0]        cap_col_q;
    logic [1:0]        cap_col_d;
    logic [3:0]        key_code_q;
    logic [3:0]        key_code_d;
    logic              data_ready_q;
    logic              data_ready_d;

    logic              sample_s;
    logic              sample_hit_s;
    logic [1:0]        hit_col_s;
    logic [1:0]        cur_row_s;

    assign sample_s     = (slot_cnt_q == SLOT_LAST);
    assign sample_hit_s = (col_s_q != 4'hF);
    assign hit_col_s    = lowest_low_col(col_s_q);
    assign cur_row_s    = row_index(row_q);

    // Two-flop synchronizer for the asynchronous column inputs
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            col_meta_q <= 4'hF;
            col_s_q    <= 4'hF;
        end else begin
            col_meta_q <= col_in;
            col_s_q    <= col_meta_q;
        end
    end

    // Free-running slot counter, independent of the FSM state
    always_comb begin
        slot_cnt_d = slot_cnt_q;
        if (sample_s) begin
            slot_cnt_d = '0;
        end else begin
            slot_cnt_d = slot_cnt_q + SLOT_W'(1);
        end
    end

    // Scan / debounce / held next-state and output logic, evaluated only at sample points
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        deb_cnt_d    = deb_cnt_q;
        cap_row_d    = cap_row_q;
        cap_col_d    = cap_col_q;
        key_code_d   = key_code_q;
        data_ready_d = 1'b0;
        if (sample_s) begin
            case (state_q)
                ST_SCAN: begin
                    if (sample_hit_s) begin
                        cap_row_d = cur_row_s;
                        cap_col_d = hit_col_s;
                        deb_cnt_d = DEB_W'(1);
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        row_d = next_row(row_q);
                    end
                end
                ST_DEBOUNCE: begin
                    if (sample_hit_s && (hit_col_s == cap_col_q)) begin
                        if (deb_cnt_q >= DEB_LAST) begin
                            key_code_d   = {cap_row_q, cap_col_q};
                            data_ready_d = 1'b1;
                            deb_cnt_d    = '0;
                            state_d      = ST_HELD;
                        end else begin
                            deb_cnt_d = deb_cnt_q + DEB_W'(1);
                        end
                    end else begin
                        deb_cnt_d = '0;
                        state_d   = ST_SCAN;
                        row_d     = next_row(row_q);
                    end
                end
                ST_HELD: begin
                    if (!sample_hit_s) begin
                        if (deb_cnt_q >= DEB_LAST) begin
                            deb_cnt_d = '0;
                            state_d   = ST_SCAN;
                            row_d     = next_row(row_q);
                        end else begin
                            deb_cnt_d = deb_cnt_q + DEB_W'(1);
                        end
                    end else begin
                        deb_cnt_d = '0;
                    end
                end
                default: begin
                    deb_cnt_d = '0;
                    state_d   = ST_SCAN;
                    row_d     = 4'b1110;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            slot_cnt_q   <= '0;
            row_q        <= 4'b1110;
            state_q      <= ST_SCAN;
            deb_cnt_q    <= '0;
            cap_row_q    <= 2'd0;
            cap_col_q    <= 2'd0;
            key_code_q   <= 4'd0;
            data_ready_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            row_q        <= row_d;
            state_q      <= state_d;
            deb_cnt_q    <= deb_cnt_d;
            cap_row_q    <= cap_row_d;
            cap_col_q    <= cap_col_d;
            key_code_q   <= key_code_d;
            data_ready_q <= data_ready_d;
        end
    end

    assign row_out           = row_q;
    assign key_if.key_code   = key_code_q;
    assign key_if.data_ready = data_ready_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: combinational keypad matrix, slot-level reference model
// of the scan/debounce rules, directed scenarios plus randomized key sequences.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    logic        clk = 1'b0;
    logic        reset_in;
    logic [3:0]  row_out;
    logic [3:0]  col_in;
    logic [15:0] key_mask;   // bit r*4+c = key (r,c) pressed

    int n_checks = 0;
    int n_fail   = 0;
    int pulses_total = 0;
    int slot_no = 0;

    // Slot-level reference model: 0 scanning, 1 debouncing, 2 held
    int         m_state;
    int         m_row;
    int         m_cap_row;
    int         m_cap_col;
    int         m_cnt;
    logic [3:0] m_code;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEB)
    ) dut (
        .clk      (clk),
        .reset_in (reset_in),
        .row_out  (row_out),
        .col_in   (col_in),
        .key_if   (kif.master)
    );

    always #5 clk = ~clk;

    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (row_out[r] == 1'b0 && key_mask[r*4+c]) col_in[c] = 1'b0;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete (got timeout, required $finish)");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_state = 0;
        m_row   = 0;
        m_cnt   = 0;
        m_code  = 4'd0;
    endtask

    task automatic model_step(input logic [15:0] keys, output bit pulse);
        int col;
        col   = -1;
        pulse = 1'b0;
        for (int c = 3; c >= 0; c--) if (keys[m_row*4+c]) col = c;
        case (m_state)
            0: begin
                if (col >= 0) begin
                    m_cap_row = m_row; m_cap_col = col; m_cnt = 1; m_state = 1;
                end else m_row = (m_row + 1) % 4;
            end
            1: begin
                if (col == m_cap_col) begin
                    m_cnt++;
                    if (m_cnt == DEB) begin
                        m_code = 4'(m_cap_row * 4 + m_cap_col);
                        pulse = 1'b1; m_cnt = 0; m_state = 2;
                    end
                end else begin
                    m_cnt = 0; m_state = 0; m_row = (m_row + 1) % 4;
                end
            end
            default: begin
                if (col < 0) begin
                    m_cnt++;
                    if (m_cnt == DEB) begin
                        m_cnt = 0; m_state = 0; m_row = (m_row + 1) % 4;
                    end
                end else m_cnt = 0;
            end
        endcase
    endtask

    // One scan slot with a fixed key set; checks every cycle's data_ready, then code and row.
    task automatic run_slot(input logic [15:0] keys);
        logic [3:0] dr_seen;
        logic [3:0] exp_row;
        logic [3:0] exp_dr;
        bit         pulse;
        key_mask = keys;
        for (int i = 0; i < SCAN_DIV; i++) begin
            @(posedge clk);
            #1;
            dr_seen[i] = kif.data_ready;
        end
        slot_no++;
        model_step(keys, pulse);
        if (pulse) pulses_total++;
        exp_dr  = {pulse, 3'b000};
        exp_row = 4'hF;
        exp_row[m_row] = 1'b0;
        n_checks++;
        if (dr_seen !== exp_dr) begin
            n_fail++;
            $display("FAIL dr_pattern slot %0d keys %h: got %b required %b", slot_no, keys, dr_seen, exp_dr);
        end
        n_checks++;
        if (kif.key_code !== m_code) begin
            n_fail++;
            $display("FAIL key_code slot %0d: got %b required %b", slot_no, kif.key_code, m_code);
        end
        n_checks++;
        if (row_out !== exp_row) begin
            n_fail++;
            $display("FAIL row_out slot %0d: got %b required %b", slot_no, row_out, exp_row);
        end
    endtask

    task automatic run_slots(input logic [15:0] keys, input int n);
        for (int i = 0; i < n; i++) run_slot(keys);
    endtask

    // Bounded wait: run slots until the model reaches a state (and row, if >= 0).
    task automatic wait_until(input int st, input int row, input logic [15:0] keys, input int max_slots);
        int n;
        n = 0;
        while (!(m_state == st && (row < 0 || m_row == row)) && n < max_slots) begin
            run_slot(keys);
            n++;
        end
        n_checks++;
        if (!(m_state == st && (row < 0 || m_row == row))) begin
            n_fail++;
            $display("FAIL wait_until: got state %0d row %0d, required state %0d row %0d", m_state, m_row, st, row);
        end
    endtask

    task automatic check_val(input string name, input logic [3:0] got, input logic [3:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, got, req);
        end
    endtask

    task automatic check_pulses(input string name, input int got, input int req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d pulses required %0d", name, got, req);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_in = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset_in = 1'b0;
        key_mask = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_row_out", row_out, 4'b1110);
        check_val("reset_key_code", kif.key_code, 4'b0000);
        check_val("reset_data_ready", {3'b000, kif.data_ready}, 4'b0000);
        release_reset();
        run_slots(16'h0000, 6);
    endtask

    task automatic test_press_five();
        int p0;
        p0 = pulses_total;
        run_slots(16'h0020, 20);
        check_pulses("five_first_press", pulses_total - p0, 1);
        check_val("five_code_1", kif.key_code, 4'b0101);
        run_slots(16'h0000, 5);
        p0 = pulses_total;
        run_slots(16'h0020, 20);
        check_pulses("five_second_press", pulses_total - p0, 1);
        check_val("five_code_2", kif.key_code, 4'b0101);
        run_slots(16'h0000, 5);
    endtask

    task automatic test_zero_then_d();
        run_slots(16'h2000, 12);
        check_val("zero_code", kif.key_code, 4'b1101);
        run_slots(16'h0000, 5);
        run_slots(16'h8000, 12);
        check_val("d_code", kif.key_code, 4'b1111);
        run_slots(16'h0000, 5);
    endtask

    task automatic test_bounce();
        int         p0;
        logic [3:0] code0;
        wait_until(0, 2, 16'h0000, 12);
        p0    = pulses_total;
        code0 = kif.key_code;
        run_slot(16'h0200);
        run_slot(16'h0000);
        check_val("bounce_row_advances", row_out, 4'b0111);
        run_slots(16'h0000, 3);
        check_pulses("bounce_no_pulse", pulses_total - p0, 0);
        check_val("bounce_code_kept", kif.key_code, code0);
    endtask

    task automatic test_two_keys();
        int p0;
        p0 = pulses_total;
        run_slots(16'h0050, 36);
        check_pulses("two_keys_one_pulse", pulses_total - p0, 1);
        check_val("two_keys_code", kif.key_code, 4'b0100);
        run_slots(16'h0000, 5);
    endtask

    task automatic test_release_bounce();
        int p0;
        p0 = pulses_total;
        wait_until(2, -1, 16'h0400, 12);
        run_slot(16'h0000);
        run_slot(16'h0400);
        run_slots(16'h0000, 2);
        check_val("held_row_frozen", row_out, 4'b1011);
        run_slot(16'h0000);
        check_val("held_row_resumes", row_out, 4'b0111);
        run_slots(16'h0000, 3);
        check_pulses("release_bounce_one_pulse", pulses_total - p0, 1);
        check_val("release_bounce_code", kif.key_code, 4'b1010);
    endtask

    task automatic test_reset_mid();
        int p0;
        wait_until(1, 0, 16'h0008, 12);
        @(posedge clk);
        #1;
        reset_in = 1'b0;
        #1;
        check_val("midreset_row_out", row_out, 4'b1110);
        check_val("midreset_key_code", kif.key_code, 4'b0000);
        check_val("midreset_data_ready", {3'b000, kif.data_ready}, 4'b0000);
        repeat (3) @(posedge clk);
        release_reset();
        p0 = pulses_total;
        run_slots(16'h0008, 12);
        check_pulses("after_reset_a_pulse", pulses_total - p0, 1);
        check_val("after_reset_a_code", kif.key_code, 4'b0011);
        run_slots(16'h0000, 5);
    endtask

    task automatic test_random();
        logic [15:0] keys;
        int          kind;
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 3));
            keys = 16'h0000;
            if (kind == 1 || kind == 2) begin
                keys[$urandom_range(0, 15)] = 1'b1;
            end else if (kind == 3) begin
                keys[$urandom_range(0, 15)] = 1'b1;
                keys[$urandom_range(0, 15)] = 1'b1;
            end else begin
                keys = 16'h0000;
            end
            run_slots(keys, int'($urandom_range(1, 8)));
        end
        run_slots(16'h0000, 5);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_press_five();
        test_zero_then_d();
        test_bounce();
        test_two_keys();
        test_release_bounce();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
